buffer_rx: RTL and testbench

Receive end of the 2-bit symbol line whose pipeline delays every symbol by four cycles and forces code 01 to 00. Samples one 2-bit symbol per clock from the line output, strips idle, deserializes parity-protected frames into bytes, and presents each byte through a one-entry valid/ready holding register. Framing, parity and overrun errors are reported as single-cycle pulses.

---
 rtl/buffer_pkg.sv | 16 +
 rtl/buffer_rx_hold.sv | 36 +++
 rtl/buffer_rx.sv | 142 ++++++++++++++
 tb/tb_buffer_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared line-symbol codes and receiver state encoding for the buffer_rx block.
package buffer_pkg;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_VIOL = 2'b01;
  localparam logic [1:0] SYM_D0   = 2'b10;
  localparam logic [1:0] SYM_D1   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/buffer_rx_hold.sv
// One-entry valid/ready holding register for received frames, with overrun detect.
module buffer_rx_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] data_p0,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              err_overrun
);

  // The slot is free when empty or when its current byte is consumed this cycle.
  logic can_load;
  assign can_load = !data_valid || data_ready;

  // Load, accept and overrun pulse; a blocked frame leaves the held byte untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= vld_p0 && !can_load;
      if (vld_p0 && can_load) begin
        data_out   <= data_p0;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/buffer_rx.sv
// Receive end of the 2-bit symbol line: idle stripping, frame deserialization,
// even-parity check and error pulses, feeding a one-entry holding register.
module buffer_rx
  import buffer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        line_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              err_parity,
  output logic              err_abort,
  output logic              err_overrun
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  rx_state_t         state, state_nxt;
  logic [DATA_W-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              par, par_nxt;
  // Set once an abort has been reported for the current bad frame, so the rest
  // of it is swallowed silently until the line goes idle.
  logic              ab_done, ab_done_nxt;
  logic [DATA_W:0]   shift_w;
  logic              vld_p0, perr_p0, abort_p0;

  // Symbol decode: next state, shift/count/parity update and error selection.
  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    cnt_nxt     = cnt;
    par_nxt     = par;
    ab_done_nxt = ab_done;
    vld_p0      = 1'b0;
    perr_p0     = 1'b0;
    abort_p0    = 1'b0;
    shift_w     = {line_in[0], sr};
    case (state)
      ST_IDLE, ST_DATA: begin
        case (line_in)
          SYM_D0, SYM_D1: begin
            sr_nxt    = shift_w[DATA_W:1];
            cnt_nxt   = (state == ST_IDLE) ? CNT_ONE : cnt + CNT_ONE;
            par_nxt   = (state == ST_IDLE) ? line_in[0] : par ^ line_in[0];
            state_nxt = ST_DATA;
            if (cnt_nxt == CNT_LAST) begin
              if (PARITY_EN) begin
                state_nxt = ST_PARITY;
              end else begin
                vld_p0      = 1'b1;
                ab_done_nxt = 1'b0;
                state_nxt   = ST_WAIT_IDLE;
              end
            end
          end
          SYM_VIOL: begin
            abort_p0    = 1'b1;
            ab_done_nxt = 1'b1;
            state_nxt   = ST_WAIT_IDLE;
          end
          default: begin
            if (state == ST_DATA) begin
              abort_p0  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        endcase
      end
      ST_PARITY: begin
        case (line_in)
          SYM_D0, SYM_D1: begin
            if (line_in[0] == par) vld_p0 = 1'b1;
            else                   perr_p0 = 1'b1;
            // A symbol beyond a finished frame is an over-length abort.
            ab_done_nxt = 1'b0;
            state_nxt   = ST_WAIT_IDLE;
          end
          SYM_VIOL: begin
            abort_p0    = 1'b1;
            ab_done_nxt = 1'b1;
            state_nxt   = ST_WAIT_IDLE;
          end
          default: begin
            abort_p0  = 1'b1;
            state_nxt = ST_IDLE;
          end
        endcase
      end
      ST_WAIT_IDLE: begin
        if (line_in == SYM_IDLE) begin
          state_nxt = ST_IDLE;
        end else if (!ab_done) begin
          abort_p0    = 1'b1;
          ab_done_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: FSM state, shift register, counter, parity and error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      sr         <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      ab_done    <= 1'b0;
      err_parity <= 1'b0;
      err_abort  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      cnt        <= cnt_nxt;
      par        <= par_nxt;
      ab_done    <= ab_done_nxt;
      err_parity <= perr_p0;
      err_abort  <= abort_p0;
    end
  end

  buffer_rx_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .vld_p0      (vld_p0),
    .data_p0     (sr_nxt),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .err_overrun (err_overrun)
  );

endmodule

// File: tb/tb_buffer_rx.sv
// Scoreboard bench for buffer_rx: expected bytes are queued as frames are driven
// and compared when the consumer accepts them; error pulses are counted.
module tb_buffer_rx;
  import buffer_pkg::*;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        line_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              err_parity;
  logic              err_abort;
  logic              err_overrun;

  int n_vec = 0;
  int n_err = 0;
  int n_par = 0;
  int n_abt = 0;
  int n_ovr = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              held = 1'b0;
  logic [DATA_W-1:0] held_val = '0;

  always #5 clk = ~clk;

  buffer_rx #(
    .DATA_W    (DATA_W),
    .PARITY_EN (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .line_in     (line_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .err_parity  (err_parity),
    .err_abort   (err_abort),
    .err_overrun (err_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; sampled at the next edge.
  task automatic sym(input logic [1:0] s);
    @(posedge clk);
    #1;
    line_in = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sym(SYM_IDLE);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] b, input bit good, input bit push);
    for (int i = 0; i < DATA_W; i++) sym(b[i] ? SYM_D1 : SYM_D0);
    sym(((^b) ^ !good) ? SYM_D1 : SYM_D0);
    if (push) exp_q.push_back(b);
  endtask

  // Monitor on the falling edge: error counting, accept scoreboard, hold stability.
  always @(negedge clk) begin
    if (reset) begin
      if (err_parity)  n_par++;
      if (err_abort)   n_abt++;
      if (err_overrun) n_ovr++;
      if (int'(err_parity) + int'(err_abort) + int'(err_overrun) > 1)
        chk("err_onehot", int'(err_parity) + int'(err_abort) + int'(err_overrun), 1);
      if (held && data_valid) chk("hold_stable", 32'(data_out), 32'(held_val));
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) chk("pending_frames", exp_q.size(), 1);
        else                   chk("data", 32'(data_out), 32'(exp_q.pop_front()));
      end
      held     = data_valid && !data_ready;
      held_val = data_out;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_abt, b_par, b_ovr;
    reset      = 1'b1;
    line_in    = SYM_IDLE;
    data_ready = 1'b1;
    #3 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_errs", 32'({err_parity, err_abort, err_overrun}), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Good frame 0x05, valid exactly one cycle after the parity sample.
    idle(1);
    send_frame(8'h05, 1'b1, 1'b1);
    chk("t1_valid_before", 32'(data_valid), 0);
    sym(SYM_IDLE);
    chk("t1_valid", 32'(data_valid), 1);
    chk("t1_data", 32'(data_out), 32'h05);
    sym(SYM_IDLE);
    chk("t1_valid_drop", 32'(data_valid), 0);
    chk("t1_errs", n_par + n_abt + n_ovr, 0);

    // Bad parity: one err_parity pulse, nothing delivered.
    send_frame(8'h05, 1'b0, 1'b0);
    sym(SYM_IDLE);
    chk("t2_perr_pulse", 32'(err_parity), 1);
    chk("t2_valid", 32'(data_valid), 0);
    sym(SYM_IDLE);
    chk("t2_perr_one_cycle", 32'(err_parity), 0);
    chk("t2_par_count", n_par, 1);

    // Truncated frame, then a good 0xA5.
    b_abt = n_abt;
    sym(SYM_D1); sym(SYM_D1); sym(SYM_D1);
    sym(SYM_IDLE);
    sym(SYM_IDLE);
    chk("t3_abort_pulse", 32'(err_abort), 1);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(3);
    chk("t3_abort_count", n_abt - b_abt, 1);
    chk("t3_drained", exp_q.size(), 0);

    // Overrun: 0x01 held, 0xFF dropped, then 0x01 accepted.
    data_ready = 1'b0;
    b_ovr = n_ovr;
    send_frame(8'h01, 1'b1, 1'b1);
    idle(1);
    send_frame(8'hFF, 1'b1, 1'b0);
    sym(SYM_IDLE);
    chk("t4_overrun_pulse", 32'(err_overrun), 1);
    chk("t4_held_data", 32'(data_out), 32'h01);
    idle(2);
    chk("t4_overrun_count", n_ovr - b_ovr, 1);
    chk("t4_still_valid", 32'(data_valid), 1);
    data_ready = 1'b1;
    sym(SYM_IDLE);
    chk("t4_valid_drop", 32'(data_valid), 0);
    chk("t4_drained", exp_q.size(), 0);

    // Violation mid-frame: single abort, trailing data ignored, IDLE after 00.
    b_abt = n_abt;
    sym(SYM_D1); sym(SYM_D0); sym(SYM_VIOL); sym(SYM_D1); sym(SYM_D1); sym(SYM_IDLE);
    idle(2);
    chk("t5_abort_count", n_abt - b_abt, 1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(2);
    chk("t5_after_abort", n_abt - b_abt, 1);
    chk("t5_drained", exp_q.size(), 0);

    // Asynchronous reset mid-frame with a byte held.
    data_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(1);
    sym(SYM_D1); sym(SYM_D0); sym(SYM_D1); sym(SYM_D0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(data_valid), 0);
    chk("t6_rst_data", 32'(data_out), 0);
    chk("t6_rst_errs", 32'({err_parity, err_abort, err_overrun}), 0);
    exp_q.delete();
    line_in    = SYM_IDLE;
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    b_abt = n_abt;
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(2);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_no_abort", n_abt - b_abt, 0);

    // Full-rate random frames with a single idle between them.
    b_abt = n_abt; b_par = n_par; b_ovr = n_ovr;
    for (int f = 0; f < 20; f++) begin
      send_frame(DATA_W'($urandom_range(0, 255)), 1'b1, 1'b1);
      sym(SYM_IDLE);
    end
    idle(3);
    chk("t7_drained", exp_q.size(), 0);
    chk("t7_no_errors", (n_abt - b_abt) + (n_par - b_par) + (n_ovr - b_ovr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
